// File: rtl/data_sram_resp_if.sv
// Data SRAM bus between the execute stage (master) and the SRAM responder (slave).
// Request:  data_sram_en, data_sram_we[3:0], data_sram_addr[31:0], data_sram_wdata[31:0]
// Response: data_sram_rdata[31:0], rdata_valid, addr_err
// Harness:  rd_cnt[31:0], wr_cnt[31:0] (accepted load/store counts)
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, rdata_valid, addr_err, rd_cnt, wr_cnt
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, rdata_valid, addr_err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/data_sram_resp.sv
// Responder end of the data SRAM interface: byte-lane stores into a word array,
// loads returned after RD_LAT cycles through a response pipeline, range errors
// and access counters reported for the harness.
// Ports: clk, resetn (async, active-low), bus (data_sram_resp_if.slave).
module data_sram_resp #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
    input  logic            clk,
    input  logic            resetn,
    data_sram_resp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LO    = ADDR_W + 2;

    // Elaboration-time configuration checks
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("data_sram_resp: RD_LAT must be in 1..4");
    end
    if (BASE_ADDR[LO-1:0] != '0) begin : g_bad_base
        $error("data_sram_resp: BASE_ADDR low bits must be zero");
    end

    logic [31:0]       mem_q [DEPTH];
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              is_store;
    logic              is_load;
    logic              ld_vld;
    logic              ld_err;
    logic [31:0]       ld_data;
    logic              st_err;
    logic              rsp_vld;
    logic              rsp_err;
    logic [31:0]       rsp_data;

    logic [31:0] rdata_q,  rdata_d;
    logic        valid_q,  valid_d;
    logic        err_q,    err_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Byte offset bits carry no meaning for word accesses
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.data_sram_addr[1:0];

    // Request decode and load snapshot (array read before this edge's write)
    always_comb begin
        in_range = (bus.data_sram_addr[31:LO] == BASE_ADDR[31:LO]);
        idx      = bus.data_sram_addr[LO-1:2];
        is_store = bus.data_sram_en && (bus.data_sram_we != 4'h0);
        is_load  = bus.data_sram_en && (bus.data_sram_we == 4'h0);
        ld_vld   = is_load;
        ld_err   = is_load && !in_range;
        ld_data  = in_range ? mem_q[idx] : 32'h0;
        st_err   = is_store && !in_range;
    end

    // Word array; contents survive reset, requests during reset are dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // array intentionally not cleared
        end else if (is_store && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_we[i]) begin
                    mem_q[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: RD_LAT-1 internal stages, the output registers are the last
    if (RD_LAT == 1) begin : g_direct
        assign rsp_vld  = ld_vld;
        assign rsp_err  = ld_err;
        assign rsp_data = ld_data;
    end else begin : g_pipe
        localparam int unsigned D = RD_LAT - 1;
        logic        vld_q  [D];
        logic        perr_q [D];
        logic [31:0] data_q [D];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < int'(D); i++) begin
                    vld_q[i]  <= 1'b0;
                    perr_q[i] <= 1'b0;
                    data_q[i] <= 32'h0;
                end
            end else begin
                vld_q[0]  <= ld_vld;
                perr_q[0] <= ld_err;
                data_q[0] <= ld_data;
                for (int i = 1; i < int'(D); i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    perr_q[i] <= perr_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign rsp_vld  = vld_q[D-1];
        assign rsp_err  = perr_q[D-1];
        assign rsp_data = data_q[D-1];
    end

    // Output and counter next-state; store errors merge into the error pulse
    always_comb begin
        rdata_d  = rdata_q;
        valid_d  = rsp_vld;
        err_d    = (rsp_vld && rsp_err) || st_err;
        rd_cnt_d = rd_cnt_q + 32'(is_load);
        wr_cnt_d = wr_cnt_q + 32'(is_store);
        if (rsp_vld) begin
            rdata_d = rsp_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q  <= 32'h0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else begin
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign bus.rdata_valid     = valid_q;
    assign bus.addr_err        = err_q;
    assign bus.rd_cnt          = rd_cnt_q;
    assign bus.wr_cnt          = wr_cnt_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (RD_LAT 1, 2, 3) share one request
// stream; a per-latency reference model predicts responses edge by edge.
module tb_data_sram_resp;
    localparam int NL = 3;
    localparam logic [31:0] BASE = 32'h1c00_0000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    data_sram_resp_if bus1 ();
    data_sram_resp_if bus2 ();
    data_sram_resp_if bus3 ();

    assign bus1.data_sram_en = en;    assign bus1.data_sram_we = we;
    assign bus1.data_sram_addr = addr; assign bus1.data_sram_wdata = wdata;
    assign bus2.data_sram_en = en;    assign bus2.data_sram_we = we;
    assign bus2.data_sram_addr = addr; assign bus2.data_sram_wdata = wdata;
    assign bus3.data_sram_en = en;    assign bus3.data_sram_we = we;
    assign bus3.data_sram_addr = addr; assign bus3.data_sram_wdata = wdata;

    data_sram_resp #(.RD_LAT(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));
    data_sram_resp #(.RD_LAT(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bus2.slave));
    data_sram_resp #(.RD_LAT(3)) u_dut3 (.clk(clk), .resetn(resetn), .bus(bus3.slave));

    logic [31:0] rdata_a [NL];
    logic        vld_a   [NL];
    logic        err_a   [NL];
    logic [31:0] rdcnt_a [NL];
    logic [31:0] wrcnt_a [NL];

    assign rdata_a[0] = bus1.data_sram_rdata; assign vld_a[0] = bus1.rdata_valid;
    assign err_a[0] = bus1.addr_err; assign rdcnt_a[0] = bus1.rd_cnt; assign wrcnt_a[0] = bus1.wr_cnt;
    assign rdata_a[1] = bus2.data_sram_rdata; assign vld_a[1] = bus2.rdata_valid;
    assign err_a[1] = bus2.addr_err; assign rdcnt_a[1] = bus2.rd_cnt; assign wrcnt_a[1] = bus2.wr_cnt;
    assign rdata_a[2] = bus3.data_sram_rdata; assign vld_a[2] = bus3.rdata_valid;
    assign err_a[2] = bus3.addr_err; assign rdcnt_a[2] = bus3.rd_cnt; assign wrcnt_a[2] = bus3.wr_cnt;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: word contents plus expected response per (latency, edge slot)
    logic [31:0] mmem    [1024];
    bit          slot_v  [NL][8];
    bit          slot_e  [NL][8];
    logic [31:0] slot_d  [NL][8];
    logic [31:0] m_rdata [NL];
    logic [31:0] m_rd;
    logic [31:0] m_wr;

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat=%0d observed=%h expected=%h", tag, k + 1, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NL; k++) begin
            m_rdata[k] = 32'h0;
            for (int s = 0; s < 8; s++) begin
                slot_v[k][s] = 1'b0;
                slot_e[k][s] = 1'b0;
                slot_d[k][s] = 32'h0;
            end
        end
        m_rd = 32'h0;
        m_wr = 32'h0;
    endtask

    // Request accepted at edge edge_n: load answers after edge edge_n+lat-1,
    // store error shows after edge edge_n
    task automatic model_accept(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bit inr;
        int wi;
        inr = (a[31:12] == BASE[31:12]);
        wi  = int'(a[11:2]);
        if (w == 4'h0) begin
            m_rd = m_rd + 32'd1;
            for (int k = 0; k < NL; k++) begin
                slot_v[k][(edge_n + k) % 8] = 1'b1;
                slot_d[k][(edge_n + k) % 8] = inr ? mmem[wi] : 32'h0;
                slot_e[k][(edge_n + k) % 8] = slot_e[k][(edge_n + k) % 8] | !inr;
            end
        end else begin
            m_wr = m_wr + 32'd1;
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (w[b]) mmem[wi][8*b +: 8] = d[8*b +: 8];
            end else begin
                for (int k = 0; k < NL; k++) slot_e[k][edge_n % 8] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        int s;
        s = edge_n % 8;
        for (int k = 0; k < NL; k++) begin
            if (slot_v[k][s]) m_rdata[k] = slot_d[k][s];
            check("rdata_valid", k, 32'(vld_a[k]), 32'(slot_v[k][s]));
            check("addr_err", k, 32'(err_a[k]), 32'(slot_e[k][s]));
            check("rdata", k, rdata_a[k], m_rdata[k]);
            check("rd_cnt", k, rdcnt_a[k], m_rd);
            check("wr_cnt", k, wrcnt_a[k], m_wr);
            slot_v[k][s] = 1'b0;
            slot_e[k][s] = 1'b0;
        end
    endtask

    // Drive at the falling edge, accept at the rising edge, check at the next falling edge
    task automatic step(input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        edge_n++;
        if (resetn && e) model_accept(w, a, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_step();
        logic [3:0]  w;
        logic [31:0] a;
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
            if (a[31:12] == BASE[31:12]) a[31] = ~a[31];
        end else begin
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        end
        step(1'($urandom_range(0, 3) != 0), w, a, $urandom);
    endtask

    logic [31:0] val_a;
    logic [31:0] val_b;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        model_reset();

        // Reset state; requests during reset are ignored
        step(1'b1, 4'hf, BASE, 32'h1234_5678);
        step(1'b1, 4'h0, BASE, 32'h0);
        resetn = 1'b1;

        // Store then load
        step(1'b1, 4'hf, 32'h1c00_0010, 32'hDEAD_BEEF);
        step(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
        check("st_ld_data", 0, rdata_a[0], 32'hDEAD_BEEF);
        check("st_ld_valid", 0, 32'(vld_a[0]), 32'd1);
        check("st_ld_wr_cnt", 0, wrcnt_a[0], 32'd1);
        check("st_ld_rd_cnt", 0, rdcnt_a[0], 32'd1);

        // Byte-lane merge
        step(1'b1, 4'b0101, 32'h1c00_0010, 32'h1122_3344);
        step(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
        check("merge", 0, rdata_a[0], 32'hDE22_BE44);

        // Fill words 0..15 (words 0,1,2 get 1,2,3)
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'hf, BASE + 32'(4 * i), (i < 3) ? 32'(i + 1) : $urandom);

        // Pipelined loads; RD_LAT=3 answers 1,2,3 on consecutive cycles
        step(1'b1, 4'h0, BASE + 32'd0, 32'h0);
        step(1'b1, 4'h0, BASE + 32'd4, 32'h0);
        check("pipe3_early", 2, 32'(vld_a[2]), 32'd0);
        step(1'b1, 4'h0, BASE + 32'd8, 32'h0);
        check("pipe3_first", 2, rdata_a[2], 32'd1);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        check("pipe3_second", 2, rdata_a[2], 32'd2);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        check("pipe3_third", 2, rdata_a[2], 32'd3);
        check("pipe3_valid", 2, 32'(vld_a[2]), 32'd1);
        step(1'b0, 4'h0, 32'h0, 32'h0);

        // Out-of-range load and store
        step(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        check("oor_ld_valid", 0, 32'(vld_a[0]), 32'd1);
        check("oor_ld_err", 0, 32'(err_a[0]), 32'd1);
        check("oor_ld_data", 0, rdata_a[0], 32'd0);
        step(1'b1, 4'hf, 32'h1c00_1000, 32'hFFFF_FFFF);
        check("oor_st_err", 0, 32'(err_a[0]), 32'd1);
        step(1'b1, 4'h0, BASE, 32'h0);
        check("oor_st_word0", 0, rdata_a[0], 32'd1);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);

        // Snapshot vs later store (RD_LAT=2)
        val_a = mmem[5];
        val_b = ~val_a ^ 32'h0F0F_0F0F;
        step(1'b1, 4'h0, BASE + 32'd20, 32'h0);
        step(1'b1, 4'hf, BASE + 32'd20, val_b);
        check("snap_old", 1, rdata_a[1], val_a);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, BASE + 32'd20, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        check("snap_new", 1, rdata_a[1], val_b);
        step(1'b0, 4'h0, 32'h0, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) rand_step();
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 32'h0, 32'h0);

        // Reset mid-operation with two loads in flight
        step(1'b1, 4'h0, BASE + 32'd12, 32'h0);
        en = 1'b1; we = 4'h0; addr = BASE + 32'd24; wdata = 32'h0;
        @(posedge clk);
        edge_n++;
        model_accept(4'h0, addr, wdata);
        en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        for (int k = 0; k < NL; k++) begin
            check("rst_rdata", k, rdata_a[k], 32'h0);
            check("rst_valid", k, 32'(vld_a[k]), 32'h0);
            check("rst_err", k, 32'(err_a[k]), 32'h0);
            check("rst_rd_cnt", k, rdcnt_a[k], 32'h0);
            check("rst_wr_cnt", k, wrcnt_a[k], 32'h0);
        end
        model_reset();
        @(negedge clk);
        check_all();
        step(1'b1, 4'hf, BASE + 32'd8, 32'hAAAA_5555);
        step(1'b1, 4'h0, BASE, 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 32'h0, 32'h0);

        // Array contents retained across reset
        for (int i = 0; i < 16; i++) step(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 100; i++) rand_step();
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the data SRAM interface driven by the execute stage. It accepts one load or store per cycle and applies byte-lane writes to an internal word array. Read data returns after a fixed, parameterised latency through a response pipeline. Address-range errors and access statistics are reported for the test harness. It sits in the SoC/testbench shell and is connected directly to the CPU's `data_sram_*` ports.

## Interface
- `ADDR_W`, 10: word-index width; array holds 2^ADDR_W 32-bit words (4 KiB at default).
- `RD_LAT`, 1: read latency in cycles. Legal range is 1..4; any other value is a configuration error.
- `BASE_ADDR`, 32'h1c00_0000: byte base address of the array. Bits [ADDR_W+1:0] must be zero.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `data_sram_en` in 1: request valid this cycle.
- `data_sram_we` in 4: byte write enables. Nonzero means store; zero means load.
- `data_sram_addr` in 32: byte address. Bits [1:0] are ignored.
- `data_sram_wdata` in 32: store data; lane i is bits [8i+7:8i].
- `data_sram_rdata` out 32: load data. Holds its value between load responses.
- `rdata_valid` out 1: one-cycle pulse marking a load response.
- `addr_err` out 1: one-cycle pulse for an out-of-range access.
- `rd_cnt` out 32: count of accepted loads.
- `wr_cnt` out 32: count of accepted stores.

## Operation
- **Request classification.** A request is sampled at the rising edge when `data_sram_en`=1. There is no backpressure; one request is accepted every cycle.
- **Range check and word index.**
  - In range when `addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`.
  - Word index is `addr[ADDR_W+1:2]`.
- **Store** (`we`≠0):
  - In range: for each i with `we[i]`=1, `mem[idx]` lane i ← `wdata` lane i. Other lanes are unchanged.
  - Out of range: the store is suppressed.
  - `wr_cnt` increments in either case.
  - Stores produce no `rdata_valid`.
- **Load** (`we`=0):
  - `mem[idx]` is snapshotted at the accepting edge; out of range returns 32'h0.
  - The snapshot enters an RD_LAT-deep response pipeline holding valid, data and err per stage.
  - `rd_cnt` increments.
- **Response pipeline.**
  - When a stage-RD_LAT entry is valid: `data_sram_rdata` ← its data, `rdata_valid`=1, `addr_err` = its err.
  - Otherwise `rdata_valid`=0 and `data_sram_rdata` holds its value.
- **Store error reporting.** `addr_err` for an out-of-range store is asserted the cycle after acceptance. If it coincides with a load response, `addr_err` is the OR of both.
- **Ordering.**
  - A load accepted one cycle after a store to the same word returns post-store data, because the array is updated at the store's edge.
  - A store accepted while an earlier load is in flight does not alter that load's snapshot.
- **Counters** are free-running 32-bit and wrap from FFFF_FFFF to 0.
- **Reset** (`resetn`=0, any time, including mid-operation):
  - Outputs: `data_sram_rdata`=0, `rdata_valid`=0, `addr_err`=0, `rd_cnt`=0, `wr_cnt`=0.
  - All pipeline valid bits clear; in-flight loads are dropped.
  - Array contents are not reset.
  - Requests presented while `resetn`=0 are ignored.

## Timing
- **Load latency.** A load accepted at edge N drives `rdata_valid`=1 and data during the cycle after edge N+RD_LAT-1. At RD_LAT=1 this is the cycle immediately following acceptance, matching the CPU's synchronous-SRAM expectation.
- **Throughput.** Back-to-back loads give back-to-back `rdata_valid` pulses in issue order, with no bubbles.
- **Store visibility.** Store data is visible to any load accepted at edge N+1 or later.
- **Counter update.** Counters update at the accepting edge and are visible the following cycle.
- **Reset release.** The first request is accepted at the first rising edge with `resetn`=1.

## Test plan
- **Store then load, RD_LAT=1.**
  - Stimulus: store we=4'hf, addr=1c00_0010, wdata=DEADBEEF; load the same address the next cycle.
  - Required: next cycle `rdata_valid`=1, rdata=DEADBEEF, `wr_cnt`=1, `rd_cnt`=1.
- **Byte-lane merge.**
  - Stimulus: after the above, store we=4'b0101, wdata=11223344; then load.
  - Required: rdata=DE22BE44.
- **Pipelined loads, RD_LAT=3.**
  - Stimulus: loads to words 0, 1, 2 on consecutive cycles, pre-filled with 1, 2, 3.
  - Required: responses arrive in order 1, 2, 3 on three consecutive cycles. The first arrives 3 cycles after the first request edge.
- **Out-of-range accesses.**
  - Load 0x0000_0000 → `rdata_valid`=1, rdata=0, `addr_err`=1 together.
  - Store 1c00_1000 (ADDR_W=10) → `addr_err` pulses one cycle later; a subsequent load of word 0 is unchanged.
- **Reset mid-operation.**
  - Stimulus: RD_LAT=3, issue two loads, assert `resetn`=0 asynchronously between clock edges.
  - Required: all outputs 0 immediately; no `rdata_valid` after release; array data written before reset still reads back.
- **Snapshot vs. later store.**
  - Stimulus: RD_LAT=2, load word 5 (=A) then store B to word 5 the next cycle.
  - Required: the load returns A; a later load returns B.
